// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register indices, STATUS bit positions, FSM state encoding and baud helpers.
// Optional feature macro: UART_TX_PARITY_EN (8E1 framing when defined).
package uart_pkg;

  localparam int unsigned DIV_W = 16;

  // Register index, taken from addr[1:0]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  // STATUS register bit positions
  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_EMPTY = 2;
  localparam int unsigned STAT_OVF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // A divider of zero would stall the line, so it behaves as one cycle per bit.
  function automatic logic [DIV_W-1:0] bit_period(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus port of the UART transmitter (word-addressed).
// Optional feature macro: UART_TX_PARITY_EN (no effect on this interface).
interface uart_tx_mmio_if;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        cs;
  logic        oe;
  logic        we;

  modport master (
    output addr, dataIn, cs, oe, we,
    input  dataOut
  );

  modport slave (
    input  addr, dataIn, cs, oe, we,
    output dataOut
  );
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers carrying an extra MSB so that
// full and empty are distinguished without a separate occupancy counter.
// Optional feature macro: UART_TX_PARITY_EN (no effect on this module).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  // Pointer update; pushes to a full FIFO and pops from an empty one are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + 1'b1;
      if (pop  && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage array, no reset needed since reads are gated by the pointers
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: CPU stores to TXDATA fill a small FIFO,
// a baud-rate FSM serialises bytes onto tx as 8N1 frames.
// Optional feature macro: UART_TX_PARITY_EN adds an even parity bit (8E1).
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned      FIFO_DEPTH  = 4,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd868
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_mmio_if.slave bus,
  output logic         tx,
  output logic         irq
);

  tx_state_t        state;
  logic [DIV_W-1:0] baud_div;
  logic [DIV_W-1:0] baud_cnt;
  logic [DIV_W-1:0] reload;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             overflow;
  logic             busy;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  logic             sel;
  logic [1:0]       idx;
  logic             push_req;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic             unused_data_hi;

  assign sel      = bus.cs && (bus.addr[31:2] == BASE_ADDR[31:2]);
  assign idx      = bus.addr[1:0];
  assign push_req = sel && bus.we && (idx == REG_TXDATA);
  assign reload   = bit_period(baud_div) - DIV_W'(1);
  assign busy     = (state != ST_IDLE);
  assign irq      = fifo_empty && (state == ST_IDLE);
  assign unused_data_hi = ^bus.dataIn[31:16];

  // The FIFO head is consumed whenever the FSM loads a new byte: from IDLE,
  // or at the last cycle of STOP for back-to-back frames.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && (baud_cnt == '0)));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (bus.dataIn[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Bus-writable registers: BAUDDIV and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else if (sel && bus.we) begin
      case (idx)
        REG_TXDATA:  if (fifo_full) overflow <= 1'b1;
        REG_STATUS:  overflow <= 1'b0;
        REG_BAUDDIV: baud_div <= bus.dataIn[DIV_W-1:0];
        default:     ;
      endcase
    end
  end

  // Read mux, combinational from address and register state
  always_comb begin
    bus.dataOut = '0;
    if (sel && bus.oe) begin
      case (idx)
        REG_STATUS: begin
          bus.dataOut[STAT_BUSY]  = busy;
          bus.dataOut[STAT_FULL]  = fifo_full;
          bus.dataOut[STAT_EMPTY] = fifo_empty;
          bus.dataOut[STAT_OVF]   = overflow;
        end
        REG_BAUDDIV: bus.dataOut[DIV_W-1:0] = baud_div;
        default:     bus.dataOut = '0;
      endcase
    end
  end

  // Baud-rate serialiser: each bit lasts reload+1 cycles, counter reloaded at every bit start
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift    <= fifo_dout;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_dout;
`endif
            tx       <= 1'b0;
            baud_cnt <= reload;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_cnt == '0) begin
            tx       <= shift[0];
            baud_cnt <= reload;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= reload;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= ST_PARITY;
`else
              tx    <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_cnt == '0) begin
            tx       <= 1'b1;
            baud_cnt <= reload;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (baud_cnt == '0) begin
            if (!fifo_empty) begin
              shift    <= fifo_dout;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^fifo_dout;
`endif
              tx       <= 1'b0;
              baud_cnt <= reload;
              state    <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with a tx-bit scoreboard.
// Optional feature macro: UART_TX_PARITY_EN (expected frames gain a parity bit).
module tb_uart_tx_mmio;

  localparam logic [31:0] A_TX   = 32'h0000_1000;
  localparam logic [31:0] A_STAT = 32'h0000_1001;
  localparam logic [31:0] A_BAUD = 32'h0000_1002;
  localparam logic [31:0] A_RES  = 32'h0000_1003;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic irq;
  int   total = 0;
  int   bad   = 0;
  logic exp_q [$];

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .BASE_ADDR   (32'h0000_1000),
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    if (PAR) exp_q.push_back(^b);
    exp_q.push_back(1'b1);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.dataIn = d;
    @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.we = 1'b0; bus.dataIn = '0;
  endtask

  task automatic read_now(input logic [31:0] a, output logic [31:0] d);
    bus.cs = 1'b1; bus.oe = 1'b1; bus.addr = a;
    #1;
    d = bus.dataOut;
    bus.cs = 1'b0; bus.oe = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    read_now(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_level(input logic lvl, input int budget, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx === lvl) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Called on the first negedge of the bit at the queue head; checks the
  // first and last cycle of every bit, and busy during the final stop cycle.
  task automatic check_bits(input int p);
    logic        b;
    logic [31:0] st;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      check("txbit_first", 32'(tx), 32'(b));
      if (p > 1) begin
        repeat (p - 1) @(negedge clk);
        check("txbit_last", 32'(tx), 32'(b));
        if (exp_q.size() == 0) begin
          read_now(A_STAT, st);
          check("busy_in_stop", 32'(st[0]), 32'd1);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic send_one(input logic [7:0] b, input int p);
    logic [31:0] st;
    push_frame(b);
    bus_write(A_TX, {24'h0, b});
    @(negedge clk);
    check("pre_start_tx", 32'(tx), 32'd1);
    @(negedge clk);
    check_bits(p);
    read_now(A_STAT, st);
    check("idle_status", st, 32'h4);
    check("idle_irq", 32'(irq), 32'd1);
  endtask

  initial begin
    logic [31:0] st;
    bit          stayed;

    bus.cs = 1'b0; bus.oe = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.dataIn = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state and register decode
    read_now(A_STAT, st);
    check("rst_status", st, 32'h4);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd1);
    read_check("rst_bauddiv", A_BAUD, 32'd868);
    read_check("txdata_reads0", A_TX, 32'h0);
    read_check("reserved_reads0", A_RES, 32'h0);
    read_check("unselected_reads0", 32'h0000_2001, 32'h0);
    @(negedge clk);
    bus.cs = 1'b1; bus.oe = 1'b0; bus.addr = A_BAUD;
    #1;
    check("oe_low_reads0", bus.dataOut, 32'h0);
    bus.cs = 1'b0;
    bus_write(A_RES, 32'hFFFF_FFFF);
    read_check("reserved_write_ignored", A_STAT, 32'h4);
    bus_write(A_BAUD, 32'hFFFF_0004);
    read_check("bauddiv_upper0", A_BAUD, 32'h4);

    // Single frame at P=4
    send_one(8'hA5, 4);

    // Back-to-back frames at P=2
    bus_write(A_BAUD, 32'd2);
    push_frame(8'h00);
    push_frame(8'hFF);
    bus_write(A_TX, 32'h00);
    bus_write(A_TX, 32'hFF);
    wait_level(1'b0, 10, "b2b_start_seen");
    check_bits(2);
    read_now(A_STAT, st);
    check("b2b_idle_status", st, 32'h4);

    // FIFO fill and overflow at P=100
    bus_write(A_BAUD, 32'd100);
    push_frame(8'h11); push_frame(8'h22); push_frame(8'h33);
    push_frame(8'h44); push_frame(8'h55);
    bus_write(A_TX, 32'h11);
    bus_write(A_TX, 32'h22);
    bus_write(A_TX, 32'h33);
    bus_write(A_TX, 32'h44);
    bus_write(A_TX, 32'h55);
    read_check("fill_status", A_STAT, 32'h3);
    bus_write(A_TX, 32'h66);
    read_check("overflow_status", A_STAT, 32'hB);
    bus_write(A_STAT, 32'h0);
    read_check("overflow_cleared", A_STAT, 32'h3);
    // Still inside the first start bit; byte 0x11 has bit0=1, so the rise marks bit0
    check("ovf_in_start", 32'(tx), 32'(exp_q.pop_front()));
    wait_level(1'b1, 200, "ovf_bit0_seen");
    check_bits(100);
    stayed = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (tx !== 1'b1 || irq !== 1'b1) stayed = 1'b0;
      @(negedge clk);
    end
    check("dropped_byte_not_sent", 32'(stayed), 32'd1);

    // Reset in the middle of DATA bit 3
    bus_write(A_BAUD, 32'd4);
    bus_write(A_TX, 32'h52);
    bus_write(A_TX, 32'h3C);
    bus_write(A_TX, 32'h0F);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("mid_bit3_low", 32'(tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_tx_high", 32'(tx), 32'd1);
    read_now(A_STAT, st);
    check("reset_status", st, 32'h4);
    read_check("reset_bauddiv", A_BAUD, 32'd868);
    stayed = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (tx !== 1'b1) stayed = 1'b0;
      @(negedge clk);
    end
    check("queued_discarded", 32'(stayed), 32'd1);

    // BAUDDIV=0 behaves as one cycle per bit
    bus_write(A_BAUD, 32'd0);
    read_check("bauddiv_zero", A_BAUD, 32'd0);
    send_one(8'h81, 1);

    // Frame length with and without parity at P=1
    bus_write(A_BAUD, 32'd1);
    send_one(8'h07, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
